snn_timestep_scheduler: RTL and testbench

- Sequences one SNN timestep at a time and shares the neuron array's single spike-input stream between NUM_SRC requesters, such as the external AXI input and recurrent loopback.
- Arbitrates requesters round-robin into one registered output stage that drives the array's s_axis_spike_* port.
- After the host closes the timestep, drains in-flight events and waits for the array to settle, then pulses ts_done.

---
 rtl/snn_timestep_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_snn_timestep_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_timestep_scheduler.sv
// snn_timestep_scheduler
// Runs one SNN timestep at a time. NUM_SRC spike requesters share the neuron array's single
// spike input through a round-robin arbiter that feeds one registered output stage.
// After the host closes the timestep, the block drains in-flight events. It then waits for
// SETTLE_CYCLES consecutive idle array cycles and pulses ts_done.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   enable               low freezes the FSM and blocks grants; a pending output still drains
//   ts_start, ts_close   timestep control pulses (start in IDLE, close in RUN)
//   src_*                per-source event bundles (packed, source i at slice i)
//   src_ready            one-hot combinational grant
//   m_spike_*            registered event stream to the array
//   array_busy           array activity status
//   ts_done              one-cycle end-of-timestep pulse
//   timestep_count       completed timesteps (wrapping)
//   event_count          events forwarded in the current or last timestep (saturating)
//   sched_busy           high whenever the FSM is not idle
module snn_timestep_scheduler #(
  parameter int unsigned NUM_SRC         = 4,
  parameter int unsigned NEURON_ID_WIDTH = 6,
  parameter int unsigned WEIGHT_WIDTH    = 8,
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned TS_WIDTH        = 16,
  parameter int unsigned EVT_CNT_WIDTH   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               ts_start,
  input  logic                               ts_close,
  input  logic [NUM_SRC-1:0]                 src_valid,
  input  logic [NUM_SRC*NEURON_ID_WIDTH-1:0] src_dest_id,
  input  logic [NUM_SRC*WEIGHT_WIDTH-1:0]    src_weight,
  input  logic [NUM_SRC-1:0]                 src_exc_inh,
  output logic [NUM_SRC-1:0]                 src_ready,
  output logic                               m_spike_valid,
  output logic [NEURON_ID_WIDTH-1:0]         m_spike_dest_id,
  output logic [WEIGHT_WIDTH-1:0]            m_spike_weight,
  output logic                               m_spike_exc_inh,
  input  logic                               m_spike_ready,
  input  logic                               array_busy,
  output logic                               ts_done,
  output logic [TS_WIDTH-1:0]                timestep_count,
  output logic [EVT_CNT_WIDTH-1:0]           event_count,
  output logic                               sched_busy
);

  localparam int unsigned PtrW = $clog2(NUM_SRC);
  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StSettle, StDone} state_e;

  state_e                      state_q, state_d;
  logic [PtrW-1:0]             rr_q;
  logic [SetW-1:0]             settle_q, settle_d;
  logic                        vld_q;
  logic [NEURON_ID_WIDTH-1:0]  dest_q;
  logic [WEIGHT_WIDTH-1:0]     weight_q;
  logic                        exc_q;
  logic [TS_WIDTH-1:0]         ts_cnt_q;
  logic [EVT_CNT_WIDTH-1:0]    evt_cnt_q;

  logic                        grant_ok, found, xfer, evt_clr, ts_inc;
  logic [PtrW-1:0]             win_idx, rr_next;
  logic [PtrW:0]               sum;
  logic [NEURON_ID_WIDTH-1:0]  sel_dest;
  logic [WEIGHT_WIDTH-1:0]     sel_weight;
  logic                        sel_exc;

  // Round-robin search: first valid source at or after rr_q, wrapping.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    sum     = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      sum = {1'b0, rr_q} + (PtrW + 1)'(k);
      if (sum >= (PtrW + 1)'(NUM_SRC)) sum = sum - (PtrW + 1)'(NUM_SRC);
      if (!found && src_valid[sum[PtrW-1:0]]) begin
        found   = 1'b1;
        win_idx = sum[PtrW-1:0];
      end
    end
  end

  // Output slot is free when empty or being consumed this cycle.
  assign grant_ok = !rst && enable && ((state_q == StRun) || (state_q == StDrain)) &&
                    (!vld_q || m_spike_ready);
  assign xfer     = grant_ok && found;
  assign rr_next  = (win_idx == PtrW'(NUM_SRC - 1)) ? '0 : win_idx + PtrW'(1);

  always_comb begin
    src_ready = '0;
    if (xfer) src_ready[win_idx] = 1'b1;
  end

  always_comb begin
    sel_dest   = '0;
    sel_weight = '0;
    sel_exc    = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (win_idx == PtrW'(i)) begin
        sel_dest   = src_dest_id[i*NEURON_ID_WIDTH +: NEURON_ID_WIDTH];
        sel_weight = src_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        sel_exc    = src_exc_inh[i];
      end
    end
  end

  // Timestep FSM; enable=0 holds everything, including the settle count.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    evt_clr  = 1'b0;
    ts_inc   = 1'b0;
    if (enable) begin
      case (state_q)
        StIdle: begin
          if (ts_start) begin
            state_d = StRun;
            evt_clr = 1'b1;
          end
        end
        StRun: begin
          if (ts_close) state_d = StDrain;
        end
        StDrain: begin
          if ((src_valid == '0) && !vld_q) begin
            state_d  = StSettle;
            settle_d = '0;
          end
        end
        StSettle: begin
          if (array_busy) begin
            settle_d = '0;
          end else begin
            settle_d = settle_q + SetW'(1);
            if (settle_d == SetW'(SETTLE_CYCLES)) state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
          ts_inc  = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      rr_q      <= '0;
      ts_cnt_q  <= '0;
      evt_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      if (xfer) rr_q <= rr_next;
      if (ts_inc) ts_cnt_q <= ts_cnt_q + TS_WIDTH'(1);
      if (evt_clr) begin
        evt_cnt_q <= '0;
      end else if (xfer && (evt_cnt_q != {EVT_CNT_WIDTH{1'b1}})) begin
        evt_cnt_q <= evt_cnt_q + EVT_CNT_WIDTH'(1);
      end
    end
  end

  // Output stage: load on grant (also covers consume+reload), clear on bare consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= 1'b0;
      dest_q   <= '0;
      weight_q <= '0;
      exc_q    <= 1'b1;
    end else if (xfer) begin
      vld_q    <= 1'b1;
      dest_q   <= sel_dest;
      weight_q <= sel_weight;
      exc_q    <= sel_exc;
    end else if (m_spike_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign m_spike_valid   = vld_q;
  assign m_spike_dest_id = dest_q;
  assign m_spike_weight  = weight_q;
  assign m_spike_exc_inh = exc_q;
  assign ts_done         = (state_q == StDone);
  assign sched_busy      = (state_q != StIdle);
  assign timestep_count  = ts_cnt_q;
  assign event_count     = evt_cnt_q;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Bench for snn_timestep_scheduler: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_snn_timestep_scheduler;

  localparam int N   = 4;
  localparam int IDW = 6;
  localparam int WW  = 8;
  localparam int SC  = 4;
  localparam int TSW = 16;
  localparam int EW  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b1;
  logic             ts_start = 1'b0;
  logic             ts_close = 1'b0;
  logic [N-1:0]     src_valid = '0;
  logic [N*IDW-1:0] src_dest_id = '0;
  logic [N*WW-1:0]  src_weight = '0;
  logic [N-1:0]     src_exc_inh = '0;
  logic [N-1:0]     src_ready;
  logic             m_spike_valid;
  logic [IDW-1:0]   m_spike_dest_id;
  logic [WW-1:0]    m_spike_weight;
  logic             m_spike_exc_inh;
  logic             m_spike_ready = 1'b1;
  logic             array_busy = 1'b0;
  logic             ts_done;
  logic [TSW-1:0]   timestep_count;
  logic [EW-1:0]    event_count;
  logic             sched_busy;

  snn_timestep_scheduler #(
    .NUM_SRC(N), .NEURON_ID_WIDTH(IDW), .WEIGHT_WIDTH(WW),
    .SETTLE_CYCLES(SC), .TS_WIDTH(TSW), .EVT_CNT_WIDTH(EW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ts_start(ts_start), .ts_close(ts_close),
    .src_valid(src_valid), .src_dest_id(src_dest_id), .src_weight(src_weight),
    .src_exc_inh(src_exc_inh), .src_ready(src_ready),
    .m_spike_valid(m_spike_valid), .m_spike_dest_id(m_spike_dest_id),
    .m_spike_weight(m_spike_weight), .m_spike_exc_inh(m_spike_exc_inh),
    .m_spike_ready(m_spike_ready), .array_busy(array_busy), .ts_done(ts_done),
    .timestep_count(timestep_count), .event_count(event_count), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Phase: 0 idle, 1 run, 2 drain, 3 settle, 4 done.
  int mp, mptr, mvld, mdest, mw, mexc, mts, mevt, mset;

  task automatic model_reset();
    mp = 0; mptr = 0; mvld = 0; mdest = 0; mw = 0; mexc = 1;
    mts = 0; mevt = 0; mset = 0;
  endtask

  initial model_reset();

  // One compare per cycle on the falling edge, then advance the model across the next
  // rising edge using the inputs that edge will sample.
  always @(negedge clk) begin
    int win;
    int idx;
    int old_vld;
    logic [N-1:0] exp_rdy;
    if (rst) model_reset();
    win = -1;
    if (!rst && (mp == 1 || mp == 2) && enable && (mvld == 0 || m_spike_ready)) begin
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (src_valid[idx]) begin
          win = idx;
          break;
        end
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("src_ready", 32'(src_ready), 32'(exp_rdy));
    check("m_spike_valid", 32'(m_spike_valid), mvld);
    check("m_spike_dest_id", 32'(m_spike_dest_id), mdest);
    check("m_spike_weight", 32'(m_spike_weight), mw);
    check("m_spike_exc_inh", 32'(m_spike_exc_inh), mexc);
    check("ts_done", 32'(ts_done), (mp == 4) ? 1 : 0);
    check("sched_busy", 32'(sched_busy), (mp != 0) ? 1 : 0);
    check("timestep_count", 32'(timestep_count), mts);
    check("event_count", 32'(event_count), mevt);
    if (!rst) begin
      old_vld = mvld;
      if (win >= 0) begin
        mdest = int'(src_dest_id[win*IDW +: IDW]);
        mw    = int'(src_weight[win*WW +: WW]);
        mexc  = int'(src_exc_inh[win]);
        mvld  = 1;
        mptr  = (win + 1) % N;
        if (mevt < (1 << EW) - 1) mevt++;
      end else if (m_spike_ready) begin
        mvld = 0;
      end
      if (enable) begin
        case (mp)
          0: if (ts_start) begin mp = 1; mevt = 0; end
          1: if (ts_close) mp = 2;
          2: if (src_valid == '0 && old_vld == 0) begin mp = 3; mset = 0; end
          3: begin
            if (array_busy) mset = 0;
            else begin
              mset++;
              if (mset == SC) mp = 4;
            end
          end
          default: begin mp = 0; mts = (mts + 1) % (1 << TSW); end
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input int d, input int w, input bit e);
    src_dest_id[i*IDW +: IDW] = IDW'(d);
    src_weight[i*WW +: WW]    = WW'(w);
    src_exc_inh[i]            = e;
  endtask

  int order[6] = '{0, 1, 2, 3, 0, 1};
  bit pat[7]   = '{0, 0, 1, 0, 0, 0, 0};
  int g, cnt, first_done;

  initial begin
    step();
    step();
    rst = 1'b0;
    step();

    // Single event from source 2.
    ts_start = 1'b1;
    step();
    ts_start = 1'b0;
    set_src(2, 5, 'h20, 1'b1);
    src_valid = 4'b0100;
    @(negedge clk);
    check("t1_grant", 32'(src_ready), 32'h4);
    step();
    src_valid = '0;
    @(negedge clk);
    check("t1_valid", 32'(m_spike_valid), 1);
    check("t1_dest", 32'(m_spike_dest_id), 5);
    check("t1_weight", 32'(m_spike_weight), 'h20);
    check("t1_exc", 32'(m_spike_exc_inh), 1);
    check("t1_evt", 32'(event_count), 1);

    // Fairness: one event from source 3 returns the pointer to 0, then all sources valid.
    step();
    for (int i = 0; i < N; i++) set_src(i, 10 + i, 'h30 + i, i[0]);
    src_valid = 4'b1000;
    step();
    src_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      g = -1;
      for (int i = 0; i < N; i++) if (src_ready[i]) g = i;
      check("t2_grant_order", g, order[k]);
      step();
    end

    // Backpressure: slot holds source 1's event while ready is low.
    m_spike_ready = 1'b0;
    @(negedge clk);
    check("t2_evt", 32'(event_count), 8);
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_rdy", 32'(src_ready), 0);
      check("t3_hold_dest", 32'(m_spike_dest_id), 11);
      check("t3_hold_vld", 32'(m_spike_valid), 1);
      step();
      @(negedge clk);
    end
    step();
    m_spike_ready = 1'b1;
    @(negedge clk);
    check("t3_reload_grant", 32'(src_ready), 32'h4);
    step();
    @(negedge clk);
    check("t3_reload_dest", 32'(m_spike_dest_id), 12);
    check("t3_reload_vld", 32'(m_spike_valid), 1);

    // Full timestep: close with two events pending, then settle.
    step();
    m_spike_ready = 1'b0;
    src_valid     = 4'b0001;
    ts_close      = 1'b1;
    array_busy    = 1'b1;
    step();
    ts_close      = 1'b0;
    m_spike_ready = 1'b1;
    step();
    src_valid = '0;
    step();
    step();
    step();
    array_busy = 1'b0;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (ts_done) break;
      step();
    end
    check("t4_cycles_to_done", cnt, 5);
    step();
    @(negedge clk);
    check("t4_done_pulse", 32'(ts_done), 0);
    check("t4_ts_count", 32'(timestep_count), 1);
    check("t4_busy", 32'(sched_busy), 0);

    // Settle restart on a busy blip.
    step();
    ts_start = 1'b1;
    step();
    ts_start = 1'b0;
    ts_close = 1'b1;
    step();
    ts_close   = 1'b0;
    array_busy = 1'b1;
    step();
    first_done = -1;
    for (int k = 0; k < 12; k++) begin
      array_busy = (k < 7) ? pat[k] : 1'b0;
      @(negedge clk);
      if (ts_done && first_done < 0) first_done = k;
      step();
    end
    check("t5_first_done", first_done, 7);
    check("t5_ts_count", 32'(timestep_count), 2);

    // Asynchronous reset mid-run.
    ts_start = 1'b1;
    step();
    ts_start      = 1'b0;
    src_valid     = 4'b0001;
    m_spike_ready = 1'b0;
    step();
    src_valid = '0;
    step();
    #1;
    rst = 1'b1;
    #1;
    check("t6_vld", 32'(m_spike_valid), 0);
    check("t6_rdy", 32'(src_ready), 0);
    check("t6_busy", 32'(sched_busy), 0);
    check("t6_ts", 32'(timestep_count), 0);
    check("t6_evt", 32'(event_count), 0);
    step();
    rst           = 1'b0;
    m_spike_ready = 1'b1;
    ts_close      = 1'b1;
    step();
    ts_close = 1'b0;
    @(negedge clk);
    check("t6_close_ignored", 32'(sched_busy), 0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      step();
      rst           = ($urandom_range(0, 999) == 0);
      enable        = ($urandom_range(0, 9) != 0);
      src_valid     = N'($urandom & $urandom);
      src_dest_id   = (N*IDW)'($urandom);
      src_weight    = (N*WW)'($urandom);
      src_exc_inh   = N'($urandom);
      m_spike_ready = ($urandom_range(0, 3) != 0);
      array_busy    = ($urandom_range(0, 3) == 0);
      ts_start      = ($urandom_range(0, 7) == 0);
      ts_close      = ($urandom_range(0, 9) == 0);
    end
    step();
    rst = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
